// File: rtl/field_extractor.sv
// Turns progressive frames into one interlaced field per frame and rewrites control packets to WIDTH x HEIGHT/2.
// Kept beats reach the registered output one cycle after acceptance; din_ready drops only while that register holds an untaken beat.
module field_extractor #(
  parameter int SYMBOLS_PER_BEAT = 1,
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int WIDTH            = 640,
  parameter int HEIGHT           = 480,
  parameter int START_FIELD      = 0,
  localparam int DATA_WIDTH      = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din_data,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  din_startofpacket,
  input  logic                  din_endofpacket,
  output logic [DATA_WIDTH-1:0] dout_data,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  dout_startofpacket,
  output logic                  dout_endofpacket,
  output logic                  field_id,
  output logic                  frame_error
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CTRL  = 2'd1;
  localparam logic [1:0] VIDEO = 2'd2;
  localparam logic [1:0] PASS  = 2'd3;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = $clog2(HEIGHT + 1);

  localparam logic [15:0]   WIDTH_W   = 16'(WIDTH);
  localparam logic [15:0]   FHEIGHT_W = 16'(HEIGHT / 2);
  localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_PENUL = RW'(HEIGHT - 2);
  localparam logic [RW-1:0] ROW_END   = RW'(HEIGHT);
  localparam logic [3:0]    K_LAST    = 4'd9;
  localparam logic [3:0]    K_DROP    = 4'd10;
  localparam logic          FIELD_RST = 1'(START_FIELD);

  logic [1:0]            state_q, state_d;
  logic [3:0]            k_q, k_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic                  field_q, field_d;
  logic                  ferr_q, ferr_d;
  logic                  dout_valid_q;
  logic [DATA_WIDTH-1:0] dout_data_q;
  logic                  dout_sop_q, dout_eop_q;

  logic                  accept, load, out_sop, out_eop;
  logic [DATA_WIDTH-1:0] out_data, ctrl_data;
  logic [3:0]            ctrl_nib;
  logic                  keep, at_end, last_kept;

  assign din_ready = !dout_valid_q || dout_ready;
  assign accept    = din_valid && din_ready;

  // Rows past the last one saturate at ROW_END so trailing pixels are never kept.
  assign keep      = (row_q != ROW_END) && (row_q[0] == field_q);
  assign at_end    = (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign last_kept = keep && (col_q == COL_LAST) &&
                     (row_q == (field_q ? ROW_LAST : ROW_PENUL));

  always_comb begin
    case (k_q)
      4'd1:    ctrl_nib = WIDTH_W[15:12];
      4'd2:    ctrl_nib = WIDTH_W[11:8];
      4'd3:    ctrl_nib = WIDTH_W[7:4];
      4'd4:    ctrl_nib = WIDTH_W[3:0];
      4'd5:    ctrl_nib = FHEIGHT_W[15:12];
      4'd6:    ctrl_nib = FHEIGHT_W[11:8];
      4'd7:    ctrl_nib = FHEIGHT_W[7:4];
      4'd8:    ctrl_nib = FHEIGHT_W[3:0];
      4'd9:    ctrl_nib = field_q ? 4'b1100 : 4'b1000;
      default: ctrl_nib = 4'h0;
    endcase
    ctrl_data      = '0;
    ctrl_data[3:0] = ctrl_nib;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    col_d    = col_q;
    row_d    = row_q;
    field_d  = field_q;
    ferr_d   = 1'b0;
    load     = 1'b0;
    out_data = din_data;
    out_sop  = 1'b0;
    out_eop  = 1'b0;
    if (accept) begin
      case (state_q)
        IDLE: begin
          if (din_startofpacket) begin
            load    = 1'b1;
            out_sop = 1'b1;
            out_eop = din_endofpacket;
            k_d     = 4'd1;
            col_d   = '0;
            row_d   = '0;
            if (din_endofpacket)            state_d = IDLE;
            else if (din_data[3:0] == 4'hF) state_d = CTRL;
            else if (din_data[3:0] == 4'h0) state_d = VIDEO;
            else                            state_d = PASS;
          end
        end
        CTRL: begin
          if (k_q != K_DROP) begin
            load     = 1'b1;
            out_data = ctrl_data;
            out_eop  = din_endofpacket || (k_q == K_LAST);
            k_d      = k_q + 4'd1;
          end
          if (din_endofpacket) state_d = IDLE;
        end
        VIDEO: begin
          load    = keep;
          out_eop = din_endofpacket || last_kept;
          if (row_q != ROW_END) begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              row_d = row_q + RW'(1);
            end else begin
              col_d = col_q + CW'(1);
            end
          end
          if (din_endofpacket) begin
            field_d = !field_q;
            ferr_d  = !at_end;
            state_d = IDLE;
          end
        end
        default: begin
          load    = 1'b1;
          out_eop = din_endofpacket;
          if (din_endofpacket) state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      field_q <= FIELD_RST;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      col_q   <= col_d;
      row_q   <= row_d;
      field_q <= field_d;
      ferr_q  <= ferr_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
      dout_sop_q   <= 1'b0;
      dout_eop_q   <= 1'b0;
    end else if (din_ready) begin
      dout_valid_q <= load;
      if (load) begin
        dout_data_q <= out_data;
        dout_sop_q  <= out_sop;
        dout_eop_q  <= out_eop;
      end
    end
  end

  assign dout_valid         = dout_valid_q;
  assign dout_data          = dout_data_q;
  assign dout_startofpacket = dout_sop_q;
  assign dout_endofpacket   = dout_eop_q;
  assign field_id           = field_q;
  assign frame_error        = ferr_q;

endmodule
